// File: rtl/adc_sample_packer_pkg.sv
// Shared types and helpers for the ADC sample packer: FSM state encoding
// and the slot-counter width derived from the pack depth.
package adc_sample_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int PACK_N_DEF = 8;

    // Slot counter width for a given pack depth (clog2, never below 1 bit).
    function automatic int slot_w(input int pack_n);
        return (pack_n < 2) ? 1 : $clog2(pack_n);
    endfunction

endpackage

// File: rtl/adc_chan_shifter.sv
// One channel's PACK_N x SAMPLE_W shift buffer. New samples enter the LSB slot,
// so the first sample of a word ends up in the MSB slot.
module adc_chan_shifter #(
    parameter int SAMPLE_W = 16,
    parameter int PACK_N   = 8
) (
    input  logic                         clk_100M,
    input  logic                         ch_A_rst_n,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic                         shift_i,
    input  logic [SAMPLE_W-1:0]          din_i,
    output logic [PACK_N*SAMPLE_W-1:0]   buf_d_o,
    output logic [PACK_N*SAMPLE_W-1:0]   buf_q_o
);

    localparam int BUF_W = PACK_N * SAMPLE_W;

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;

    // A disabled channel is forced to zero so its packed word reads as all zeros.
    always_comb begin
        buf_d = buf_q;
        if (clr_i || !en_i) begin
            buf_d = '0;
        end else if (shift_i) begin
            buf_d = {buf_q[BUF_W-SAMPLE_W-1:0], din_i};
        end
    end

    always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
        if (!ch_A_rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_d_o = buf_d;
    assign buf_q_o = buf_q;

endmodule

// File: rtl/adc_sample_packer.sv
// Dual/multi-channel ADC sample packer: start/stop FSM, decimation, test pattern,
// one-deep output register with drop accounting, sticky over-range flags.
module adc_sample_packer
    import adc_sample_packer_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int PACK_N   = PACK_N_DEF,
    parameter int DECIM_W  = 8,
    parameter int CNT_W    = 16
) (
    input  logic                                clk_100M,
    input  logic                                ch_A_rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]          sample_in,
    input  logic                                sample_in_vld,
    input  logic [NUM_CH-1:0]                   or_in,
    input  logic                                start_sample,
    input  logic                                stop_sample,
    input  logic [NUM_CH-1:0]                   ch_en,
    input  logic [DECIM_W-1:0]                  decim_cfg,
    input  logic                                test_mode,
    output logic [NUM_CH*PACK_N*SAMPLE_W-1:0]   pack_data,
    output logic                                pack_valid,
    output logic                                pack_last,
    input  logic                                pack_ready,
    output logic                                busy,
    output logic                                alg_rst_trig,
    output logic [NUM_CH-1:0]                   overflow,
    output logic [CNT_W-1:0]                    drop_cnt,
    output logic [1:0]                          dbg_state_o
);

    localparam int SL_W = slot_w(PACK_N);
    localparam int CH_W = PACK_N * SAMPLE_W;
    localparam logic [SL_W-1:0] LAST_SLOT = SL_W'(PACK_N - 1);

    state_e                    state_q, state_d;
    logic [NUM_CH-1:0]         ch_en_q, ch_en_d;
    logic [DECIM_W-1:0]        decim_cfg_q, decim_cfg_d;
    logic                      test_mode_q, test_mode_d;
    logic [DECIM_W-1:0]        decim_q, decim_d;
    logic [SL_W-1:0]           slot_q, slot_d;
    logic [SAMPLE_W-1:0]       test_cnt_q, test_cnt_d;
    logic [NUM_CH*CH_W-1:0]    pack_data_q, pack_data_d;
    logic                      pack_valid_q, pack_valid_d;
    logic                      pack_last_q, pack_last_d;
    logic                      alg_rst_trig_q, alg_rst_trig_d;
    logic [NUM_CH-1:0]         overflow_q, overflow_d;
    logic [CNT_W-1:0]          drop_cnt_q, drop_cnt_d;

    logic                      start_go;
    logic                      accept;
    logic                      fill;
    logic                      shift;
    logic                      word_done;
    logic [NUM_CH*CH_W-1:0]    word_d;
    logic [NUM_CH*CH_W-1:0]    word_q;

    assign start_go  = (state_q == ST_IDLE) && start_sample;
    assign accept    = (state_q == ST_RUN) && sample_in_vld && (decim_q == '0);
    assign fill      = (state_q == ST_FLUSH) && (slot_q != '0);
    assign shift     = accept || fill;
    assign word_done = shift && (slot_q == LAST_SLOT);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SAMPLE_W-1:0] din;
        // Flush zero-fills one slot per cycle until the partial word is complete.
        assign din = fill        ? '0 :
                     test_mode_q ? test_cnt_q :
                                   sample_in[c*SAMPLE_W +: SAMPLE_W];

        adc_chan_shifter #(
            .SAMPLE_W (SAMPLE_W),
            .PACK_N   (PACK_N)
        ) u_shifter (
            .clk_100M   (clk_100M),
            .ch_A_rst_n (ch_A_rst_n),
            .clr_i      (start_go),
            .en_i       (ch_en_q[c]),
            .shift_i    (shift),
            .din_i      (din),
            .buf_d_o    (word_d[c*CH_W +: CH_W]),
            .buf_q_o    (word_q[c*CH_W +: CH_W])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_sample) state_d = ST_RUN;
            ST_RUN:   if (stop_sample)  state_d = ST_FLUSH;
            ST_FLUSH: if ((slot_q == '0) || (slot_q == LAST_SLOT)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output handshake: a word transfers on any cycle where pack_valid && pack_ready;
    // pack_data/pack_last stay frozen while pack_valid is high and pack_ready is low.
    always_comb begin
        ch_en_d        = ch_en_q;
        decim_cfg_d    = decim_cfg_q;
        test_mode_d    = test_mode_q;
        decim_d        = decim_q;
        slot_d         = slot_q;
        test_cnt_d     = test_cnt_q;
        pack_data_d    = pack_data_q;
        pack_valid_d   = pack_valid_q;
        pack_last_d    = pack_last_q;
        overflow_d     = overflow_q;
        drop_cnt_d     = drop_cnt_q;
        alg_rst_trig_d = (state_q == ST_FLUSH) && (state_d == ST_IDLE);

        if (start_go) begin
            ch_en_d     = ch_en;
            decim_cfg_d = decim_cfg;
            test_mode_d = test_mode;
            decim_d     = '0;
            slot_d      = '0;
            test_cnt_d  = '0;
            overflow_d  = '0;
            drop_cnt_d  = '0;
        end else begin
            if ((state_q == ST_RUN) && sample_in_vld) begin
                decim_d    = (decim_q == decim_cfg_q) ? '0 : decim_q + 1'b1;
                overflow_d = overflow_q | (or_in & ch_en_q);
            end
            if (accept) test_cnt_d = test_cnt_q + 1'b1;
            if (shift)  slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end

        if (pack_valid_q && pack_ready) pack_valid_d = 1'b0;
        if (word_done) begin
            if (!pack_valid_q || pack_ready) begin
                pack_data_d  = word_d;
                pack_valid_d = 1'b1;
                pack_last_d  = (state_q == ST_FLUSH);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100M or negedge ch_A_rst_n) begin
        if (!ch_A_rst_n) begin
            state_q        <= ST_IDLE;
            ch_en_q        <= '0;
            decim_cfg_q    <= '0;
            test_mode_q    <= 1'b0;
            decim_q        <= '0;
            slot_q         <= '0;
            test_cnt_q     <= '0;
            pack_data_q    <= '0;
            pack_valid_q   <= 1'b0;
            pack_last_q    <= 1'b0;
            alg_rst_trig_q <= 1'b0;
            overflow_q     <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            ch_en_q        <= ch_en_d;
            decim_cfg_q    <= decim_cfg_d;
            test_mode_q    <= test_mode_d;
            decim_q        <= decim_d;
            slot_q         <= slot_d;
            test_cnt_q     <= test_cnt_d;
            pack_data_q    <= pack_data_d;
            pack_valid_q   <= pack_valid_d;
            pack_last_q    <= pack_last_d;
            alg_rst_trig_q <= alg_rst_trig_d;
            overflow_q     <= overflow_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign pack_data    = pack_data_q;
    assign pack_valid   = pack_valid_q;
    assign pack_last    = pack_last_q;
    assign busy         = (state_q != ST_IDLE);
    assign alg_rst_trig = alg_rst_trig_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: directed runs with a word scoreboard popped on
// every output handshake, plus point checks of flags, counters and latency.
module tb_adc_sample_packer;

    localparam int WW = 2 * 8 * 16 + 1;

    logic           clk_100M;
    logic           ch_A_rst_n;
    logic [31:0]    sample_in;
    logic           sample_in_vld;
    logic [1:0]     or_in;
    logic           start_sample;
    logic           stop_sample;
    logic [1:0]     ch_en;
    logic [7:0]     decim_cfg;
    logic           test_mode;
    logic [255:0]   pack_data;
    logic           pack_valid;
    logic           pack_last;
    logic           pack_ready;
    logic           busy;
    logic           alg_rst_trig;
    logic [1:0]     overflow;
    logic [15:0]    drop_cnt;
    logic [1:0]     dbg_state;

    logic [WW-1:0]  exp_q[$];
    logic [15:0]    w0 [8];
    logic [15:0]    w1 [8];
    int             n_tests = 0;
    int             n_fail  = 0;

    adc_sample_packer dut (
        .clk_100M      (clk_100M),
        .ch_A_rst_n    (ch_A_rst_n),
        .sample_in     (sample_in),
        .sample_in_vld (sample_in_vld),
        .or_in         (or_in),
        .start_sample  (start_sample),
        .stop_sample   (stop_sample),
        .ch_en         (ch_en),
        .decim_cfg     (decim_cfg),
        .test_mode     (test_mode),
        .pack_data     (pack_data),
        .pack_valid    (pack_valid),
        .pack_last     (pack_last),
        .pack_ready    (pack_ready),
        .busy          (busy),
        .alg_rst_trig  (alg_rst_trig),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .dbg_state_o   (dbg_state)
    );

    // Clock and watchdog
    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk_word(input logic last);
        logic [WW-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[(7-i)*16 +: 16]       = w0[i];
            r[128 + (7-i)*16 +: 16] = w1[i];
        end
        r[256] = last;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic start_run(input logic [1:0] en, input logic [7:0] dec, input logic tm);
        ch_en        = en;
        decim_cfg    = dec;
        test_mode    = tm;
        start_sample = 1'b1;
        tick();
        start_sample = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        sample_in     = {b, a};
        or_in         = o;
        sample_in_vld = 1'b1;
        tick();
        sample_in_vld = 1'b0;
        or_in         = '0;
    endtask

    task automatic stop_and_wait(input string tag);
        bit seen;
        seen = 1'b0;
        stop_sample = 1'b1;
        tick();
        stop_sample = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (alg_rst_trig) seen = 1'b1;
            else tick();
        end
        chk({tag, "_trig"}, seen, 1);
        chk({tag, "_busy"}, busy, 0);
        tick();
        chk({tag, "_pulse"}, alg_rst_trig, 0);
    endtask

    // Scoreboard: every output handshake must match the oldest expected word.
    always @(negedge clk_100M) begin
        if (ch_A_rst_n && pack_valid && pack_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", {pack_last, pack_data}, 0);
            else chk("word", {pack_last, pack_data}, exp_q.pop_front());
        end
    end

    initial begin
        logic [15:0] a;
        ch_A_rst_n    = 1'b0;
        sample_in     = '0;
        sample_in_vld = 1'b0;
        or_in         = '0;
        start_sample  = 1'b0;
        stop_sample   = 1'b0;
        ch_en         = '0;
        decim_cfg     = '0;
        test_mode     = 1'b0;
        pack_ready    = 1'b1;
        repeat (2) @(posedge clk_100M);
        #1;
        chk("rst_outputs", {pack_data, pack_valid, pack_last, busy, alg_rst_trig, overflow, drop_cnt}, 0);
        ch_A_rst_n = 1'b1;
        tick();

        // Basic packing, both channels, no decimation
        start_run(2'b11, 8'd0, 1'b0);
        chk("busy_run", busy, 1);
        for (int i = 0; i < 8; i++) begin
            w0[i] = 16'(i + 1);
            w1[i] = 16'h100 + 16'(i);
        end
        exp_q.push_back(mk_word(1'b0));
        for (int i = 0; i < 8; i++) begin
            strobe(w0[i], w1[i], 2'b00);
            if (i == 6) chk("no_vld_early", pack_valid, 0);
        end
        chk("lat_vld", pack_valid, 1);
        chk("lat_last", pack_last, 0);
        tick();
        stop_and_wait("t1");

        // Decimation by 4
        start_run(2'b11, 8'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w0[i] = 16'(i * 4);
            w1[i] = 16'(i * 4) + 16'h40;
        end
        exp_q.push_back(mk_word(1'b0));
        for (int i = 0; i < 32; i++) strobe(16'(i), 16'(i) + 16'h40, 2'b00);
        tick();
        stop_and_wait("t2");

        // Partial word flushed with zero fill
        start_run(2'b11, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w0[i] = (i < 3) ? 16'($urandom_range(1, 65535)) : 16'h0;
            w1[i] = (i < 3) ? 16'($urandom_range(1, 65535)) : 16'h0;
        end
        exp_q.push_back(mk_word(1'b1));
        for (int i = 0; i < 3; i++) strobe(w0[i], w1[i], 2'b00);
        stop_and_wait("t3");
        chk("t3_sb_drained", exp_q.size(), 0);

        // Backpressure: first word held, two dropped
        pack_ready = 1'b0;
        start_run(2'b11, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w0[i] = 16'($urandom_range(0, 65535));
            w1[i] = 16'($urandom_range(0, 65535));
        end
        exp_q.push_back(mk_word(1'b0));
        for (int i = 0; i < 24; i++) begin
            if (i < 8) strobe(w0[i], w1[i], 2'b00);
            else strobe(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'b00);
        end
        chk("hold_valid", pack_valid, 1);
        chk("hold_data", {pack_last, pack_data}, mk_word(1'b0));
        chk("drop_cnt", drop_cnt, 2);
        pack_ready = 1'b1;
        tick();
        tick();
        chk("post_hs_valid", pack_valid, 0);
        stop_and_wait("t4");

        // Test pattern on channel 0 only
        start_run(2'b01, 8'd0, 1'b1);
        chk("drop_cleared", drop_cnt, 0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                w0[i] = 16'(w * 8 + i);
                w1[i] = 16'h0;
            end
            exp_q.push_back(mk_word(1'b0));
        end
        for (int i = 0; i < 16; i++)
            strobe(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'b00);
        tick();
        stop_and_wait("t5");

        // Over-range on a non-accepted strobe, then reset mid-word
        start_run(2'b11, 8'd1, 1'b0);
        chk("ovf_cleared", overflow, 0);
        a = 16'($urandom_range(0, 65535));
        strobe(a, a, 2'b00);
        strobe(a, a, 2'b10);
        chk("ovf_set", overflow, 2'b10);
        strobe(a, a, 2'b00);
        strobe(a, a, 2'b00);
        strobe(a, a, 2'b00);
        chk("ovf_sticky", overflow, 2'b10);
        ch_A_rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {pack_data, pack_valid, pack_last, busy, alg_rst_trig, overflow, drop_cnt}, 0);
        tick();
        tick();
        ch_A_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pack_valid) begin
                chk("rst_no_word", pack_valid, 0);
                break;
            end
        end
        chk("rst_idle", busy, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Parametrised successor to the dual-channel ADC sample capture/packing logic.
- Packs PACK_N consecutive samples per channel into one wide word per channel, with start/stop control, decimation, test-pattern mode, per-channel enables and overflow tracking.
- Runs entirely in the clk_100M domain, after the ADC data has been resynchronised.
- Output feeds the algorithm/DMA path through a valid/ready handshake with drop accounting.

Parameters:
- NUM_CH, 2, number of ADC channels packed in lockstep.
- SAMPLE_W, 16, bits per sample.
- PACK_N, 8, samples per packed word per channel (power of two, >= 2).
- DECIM_W, 8, width of the decimation configuration.
- CNT_W, 16, width of the drop counter.

Ports:
- clk_100M  in  1  processing clock.
- ch_A_rst_n  in  1  reset, asynchronous, active-low.
- sample_in  in  NUM_CH*SAMPLE_W  channel c at [c*SAMPLE_W +: SAMPLE_W].
- sample_in_vld  in  1  one common strobe for all channels.
- or_in  in  NUM_CH  per-channel ADC over-range, qualified by sample_in_vld.
- start_sample  in  1  level or pulse; IDLE->RUN.
- stop_sample  in  1  level or pulse; RUN->FLUSH.
- ch_en  in  NUM_CH  channel enable, sampled only in IDLE.
- decim_cfg  in  DECIM_W  accept 1 of every decim_cfg+1 valid samples, sampled only in IDLE.
- test_mode  in  1  replace samples with the counter pattern, sampled only in IDLE.
- pack_data  out  NUM_CH*PACK_N*SAMPLE_W  packed words, channel-major.
- pack_valid  out  1  word available.
- pack_last  out  1  qualifies the final (flushed) word of a run.
- pack_ready  in  1  downstream accepts when pack_valid && pack_ready.
- busy  out  1  state != IDLE.
- alg_rst_trig  out  1  one-cycle pulse on the FLUSH->IDLE transition.
- overflow  out  NUM_CH  sticky over-range per enabled channel; cleared on IDLE->RUN.
- drop_cnt  out  CNT_W  saturating count of words lost to backpressure; cleared on IDLE->RUN.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal slot counter, decimation counter and test counter all 0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE->RUN on start_sample. This latches ch_en, decim_cfg and test_mode, and clears overflow, drop_cnt and the pack buffers.
  - RUN->FLUSH on stop_sample. start_sample and stop_sample asserted together in IDLE: start wins. Both asserted in RUN: stop wins.
  - FLUSH->IDLE once any partial word is emitted (or immediately if the slot counter is 0). alg_rst_trig pulses on that cycle.
- Accept condition (RUN only): sample_in_vld && decim counter == 0.
  - The decim counter counts valid strobes 0..decim_cfg and then wraps.
  - decim_cfg = 0 accepts every strobe.
- On accept:
  - Each enabled channel shifts its buffer left by SAMPLE_W and inserts the new sample in the LSB slot. The first sample of a word therefore ends in the MSB slot.
  - Disabled channels hold zero.
  - In test_mode every enabled channel inserts test_cnt (SAMPLE_W bits), which increments per accept and wraps.
- Slot counter counts 0..PACK_N-1.
  - The accept that fills slot PACK_N-1 completes a word.
  - The completed word is copied to the output register the next cycle: latency from completing sample_in_vld to pack_valid is 1 clock.
  - The slot counter returns to 0.
- Output register: one deep.
  - pack_valid holds, with pack_data/pack_last stable, until pack_ready.
  - If a new word completes while pack_valid && !pack_ready: the new word is discarded and drop_cnt increments, saturating at all-ones.
  - A handshake and a new completion in the same cycle is not a drop; the new word loads.
- FLUSH with slot counter k > 0:
  - The remaining PACK_N-k slots are zero-filled by shifting left.
  - The word is emitted with pack_last = 1 under the same drop rule.
  - A drop in FLUSH still exits to IDLE.
  - With k = 0, no word is emitted.
- overflow[c] sets when sample_in_vld && or_in[c] && ch_en_latched[c] in RUN, including non-accepted strobes. It holds until the next IDLE->RUN.
- Asserting ch_A_rst_n low mid-run returns to reset values immediately; no partial word is emitted.

Decomposition:
- Shared package: state enum (IDLE/RUN/FLUSH) and localparam SLOT_W = clog2(PACK_N).
- One sub-module, adc_chan_shifter: one channel's SAMPLE_W x PACK_N shift buffer with enable/clear/zero-fill. It is instantiated NUM_CH times in a generate loop.
- The top level holds the FSM, counters, output register and flags.

Test Plan:
- Defaults, ch_en = 11, decim 0, ready = 1; start, then 8 strobes with CH0 = 1..8, CH1 = 0x100..0x107 -> one pack_valid 1 clock after the 8th strobe; CH0 word MSB→LSB 1..8; pack_last = 0.
- decim_cfg = 3, 32 strobes with values 0..31 -> 1 word containing samples 0,4,8..28.
- Stop after 3 accepted samples (A, B, C) -> word [A,B,C,0,0,0,0,0] with pack_last = 1, followed by an alg_rst_trig pulse and busy = 0.
- pack_ready = 0 for 24 strobes -> first word held stable, drop_cnt = 2; raising ready gives a handshake on the first word only.
- test_mode = 1, ch_en = 01 -> CH0 word 0..7, then 8..15; CH1 all zero.
- or_in[1] pulsed on a non-accepted strobe (decim 1) -> overflow = 10 sticky. Then pull ch_A_rst_n low mid-word -> all outputs 0 and no word emitted.
